data_mem_resp: RTL and testbench
================================

# data_mem_resp

Word-addressed data memory that answers the processor's LOAD/STORE requests, i.e. the responder behind the execute-stage memory port. The execute stage presents address, store data and write enable, and this block accepts the request with a valid/ready handshake. After a programmable number of wait states it commits the store or returns load data with a single-cycle response strobe. Out-of-range and misaligned accesses are rejected with an error flag instead of touching the array.

## Interface
- `DEPTH`, 256: number of 32-bit words, power of two, ≥ 2; `AW = $clog2(DEPTH)`
- `WAIT_CYCLES`, 1: extra cycles between accept and response, 0–15
- `clk_i`  in  1  clock, all state on rising edge
- `arst_ni`  in  1  reset; asynchronous, active-low
- `req_valid_i`  in  1  request present
- `req_ready_o`  out  1  block can accept a request
- `addr_i`  in  DATA_WIDTH  byte address (`mem_addr` from execute stage)
- `we_i`  in  1  1 = STORE, 0 = LOAD
- `wdata_i`  in  DATA_WIDTH  store data
- `rsp_valid_o`  out  1  one-cycle response strobe
- `rdata_o`  out  DATA_WIDTH  load data; 0 for stores and errors
- `err_o`  out  1  qualified by `rsp_valid_o`; access rejected

## Operation
- FSM states are `IDLE`, `WAIT` and `RESP`. `req_ready_o = (state == IDLE)`.
- **IDLE**
  - On `req_valid_i & req_ready_o`, capture `addr_i`, `we_i` and `wdata_i` into request registers.
  - Go to `RESP` if `WAIT_CYCLES == 0`; otherwise load `wait_cnt = WAIT_CYCLES-1` and go to `WAIT`.
- **WAIT**
  - Decrement `wait_cnt`. Go to `RESP` when `wait_cnt == 0`.
  - Inputs are ignored; `req_ready_o = 0`.
- **RESP**
  - Drive `rsp_valid_o = 1` for exactly one cycle, then return to `IDLE`.
  - Responses cannot be back-pressured.
- **Error check**, on the captured address:
  - misaligned: `addr[1:0] != 0`
  - out of range: `addr[DATA_WIDTH-1:AW+2] != 0`
  - Either condition gives `err_o = 1` and `rdata_o = 0`, and no write occurs.
- **Word index** is `addr[AW+1:2]`.
- **STORE** (no error): the array word is written on the clock edge that ends `RESP`. `rdata_o = 0`.
- **LOAD** (no error): the array is read synchronously. The read is issued the cycle before `RESP`, so `rdata_o` holds the word during `RESP`.
- **Array contents** are not reset. A load from a never-written word returns X, and the bench must not rely on it.
- **Output hold:** `rdata_o` and `err_o` are 0 whenever `rsp_valid_o = 0`.

## Timing
- **Reset:** while `arst_ni = 0`, state = `IDLE`, `wait_cnt = 0` and request registers = 0. Outputs: `req_ready_o = 1`, `rsp_valid_o = 0`, `rdata_o = 0`, `err_o = 0`.
- **Latency:** a request accepted at edge T gives `rsp_valid_o` high in cycle T+1+`WAIT_CYCLES`. `req_ready_o` is high again the following cycle.
- **Throughput:** one request per `WAIT_CYCLES+2` cycles.
- **Read-after-write:** a LOAD accepted in the cycle right after a STORE response returns the new data. The write is complete before the next read is issued.
- **Back-to-back:** `req_valid_i` held high with changing `addr_i` during `WAIT`/`RESP` has no effect. Only the value present when `req_ready_o` is high is captured.
- **Reset mid-operation:** the pending request is discarded, no write is committed, and no response is issued.
- **Error responses** have the same latency as normal responses.

## Structure
- `simple_processor_pkg` supplies `DATA_WIDTH`.
- Add the following to `simple_processor_pkg`:
  - `dmem_state_t` enum (`DMEM_IDLE`, `DMEM_WAIT`, `DMEM_RESP`)
  - `DMEM_DEPTH_DEFAULT = 256`
  - `DMEM_WAIT_DEFAULT = 1`
- Sub-module `dmem_array`: a single-port synchronous RAM holding `DEPTH × DATA_WIDTH` words. Ports are `clk_i`, `en_i`, `we_i`, `addr_i[AW-1:0]`, `wdata_i` and `rdata_o` (registered, read-first), with no reset. Keeping it separate lets it be replaced by a vendor macro.

## Test plan
- **Reset values:** assert `arst_ni = 0` mid-`WAIT` of a STORE to word 5 (0xDEAD_BEEF), then release. Expect `req_ready_o = 1` and no `rsp_valid_o`. A later LOAD of word 5 after a known write of 0x1111_1111 returns 0x1111_1111.
- **Store/load, `WAIT_CYCLES = 1`:**
  - STORE `addr 0x10` data 0xA5A5_0001 → `rsp_valid_o` in cycle T+2, `err_o = 0`, `rdata_o = 0`.
  - LOAD `0x10` → `rdata_o = 0xA5A5_0001` at T+2.
- **Zero wait:** with `WAIT_CYCLES = 0`, a LOAD gets its response at T+1. Back-to-back requests are accepted every 2 cycles.
- **Misaligned:** STORE `addr 0x13` → `err_o = 1`, `rdata_o = 0`, and a LOAD of `0x10` still returns its previous value.
- **Out of range** (`DEPTH = 256`): LOAD `addr 0x400` → `err_o = 1`, `rdata_o = 0`.
- **Boundary/ignore:**
  - STORE to the last word `0x3FC`, then LOAD it → data matches.
  - Toggling `req_valid_i`/`addr_i` during `WAIT` produces no extra responses.

Source files
------------

// File: rtl/simple_processor_pkg.sv
// Shared processor types and constants, including the data-memory responder's
// state encoding, defaults and request record.
package simple_processor_pkg;

  localparam int unsigned DATA_WIDTH         = 32;
  localparam int unsigned DMEM_DEPTH_DEFAULT = 256;
  localparam int unsigned DMEM_WAIT_DEFAULT  = 1;
  localparam int unsigned DMEM_WCNT_W        = 4;

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_WAIT,
    DMEM_RESP
  } dmem_state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] addr;
    logic                  we;
    logic [DATA_WIDTH-1:0] wdata;
  } dmem_req_t;

  // A byte address is rejected if it is not word aligned or lies above the array.
  function automatic logic dmem_addr_err(input logic [DATA_WIDTH-1:0] addr,
                                         input int unsigned aw);
    return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != '0);
  endfunction

endpackage

// File: rtl/data_mem_resp_if.sv
// Execute-stage memory port: request handshake plus single-cycle response.
interface data_mem_resp_if
  import simple_processor_pkg::*;
;
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [DATA_WIDTH-1:0] addr_i;
  logic                  we_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic                  rsp_valid_o;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  err_o;

  modport master (
    output req_valid_i, addr_i, we_i, wdata_i,
    input  req_ready_o, rsp_valid_o, rdata_o, err_o
  );

  modport slave (
    input  req_valid_i, addr_i, we_i, wdata_i,
    output req_ready_o, rsp_valid_o, rdata_o, err_o
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, read-first, no reset; swappable for a vendor macro.
module dmem_array #(
  parameter  int unsigned DEPTH = 256,
  parameter  int unsigned DW    = 32,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end
      rdata_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/data_mem_resp.sv
// Word-addressed data memory answering LOAD/STORE requests after a fixed
// number of wait states, rejecting misaligned and out-of-range accesses.
module data_mem_resp
  import simple_processor_pkg::*;
#(
  parameter int unsigned DEPTH       = DMEM_DEPTH_DEFAULT,
  parameter int unsigned WAIT_CYCLES = DMEM_WAIT_DEFAULT
) (
  input  logic            clk_i,
  input  logic            arst_ni,
  data_mem_resp_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  dmem_state_t            state_q, state_d;
  logic [DMEM_WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  dmem_req_t              req_q, req_d;
  logic                   req_err;
  logic                   ram_rd, ram_wr;
  logic [DATA_WIDTH-1:0]  ram_rdata;

  assign req_err = dmem_addr_err(req_q.addr, AW);

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q    <= DMEM_IDLE;
      wait_cnt_q <= '0;
      req_q      <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      req_q      <= req_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    req_d      = req_q;
    case (state_q)
      DMEM_IDLE: begin
        if (bus.req_valid_i) begin
          req_d = '{addr: bus.addr_i, we: bus.we_i, wdata: bus.wdata_i};
          if (WAIT_CYCLES == 0) begin
            state_d = DMEM_RESP;
          end else begin
            wait_cnt_d = DMEM_WCNT_W'(WAIT_CYCLES - 1);
            state_d    = DMEM_WAIT;
          end
        end
      end
      DMEM_WAIT: begin
        if (wait_cnt_q == '0) begin
          state_d = DMEM_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - DMEM_WCNT_W'(1);
        end
      end
      DMEM_RESP: state_d = DMEM_IDLE;
      default:   state_d = DMEM_IDLE;
    endcase
  end

  // Loads read on the edge entering RESP; stores commit on the edge leaving it.
  // req_d equals the request being served in every state, so it also drives the address.
  always_comb begin
    ram_rd = (state_d == DMEM_RESP) && (state_q != DMEM_RESP) &&
             !req_d.we && !dmem_addr_err(req_d.addr, AW);
    ram_wr = (state_q == DMEM_RESP) && req_q.we && !req_err;
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .DW    (DATA_WIDTH)
  ) u_array (
    .clk_i   (clk_i),
    .en_i    (ram_rd | ram_wr),
    .we_i    (ram_wr),
    .addr_i  (req_d.addr[AW+1:2]),
    .wdata_i (req_q.wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    bus.req_ready_o = (state_q == DMEM_IDLE);
    bus.rsp_valid_o = 1'b0;
    bus.err_o       = 1'b0;
    bus.rdata_o     = '0;
    if (state_q == DMEM_RESP) begin
      bus.rsp_valid_o = 1'b1;
      bus.err_o       = req_err;
      bus.rdata_o     = (!req_q.we && !req_err) ? ram_rdata : '0;
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: one instance with one wait state, one with none.
module tb_data_mem_resp;

  localparam int unsigned DEPTH = 256;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  data_mem_resp_if if1 ();
  data_mem_resp_if if0 ();

  data_mem_resp #(.DEPTH(DEPTH), .WAIT_CYCLES(1)) u_dut1 (
    .clk_i (clk), .arst_ni (arst_n), .bus (if1)
  );
  data_mem_resp #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk_i (clk), .arst_ni (arst_n), .bus (if0)
  );

  typedef struct {
    int          sel;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          junk;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        tbl [12];
  logic [31:0] mdl   [2][DEPTH];
  bit          known [2][DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic we,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel == 1) begin
      if1.req_valid_i = v; if1.we_i = we; if1.addr_i = a; if1.wdata_i = d;
    end else begin
      if0.req_valid_i = v; if0.we_i = we; if0.addr_i = a; if0.wdata_i = d;
    end
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 1) ? if1.req_ready_o : if0.req_ready_o;
  endfunction
  function automatic logic get_rsp(input int sel);
    return (sel == 1) ? if1.rsp_valid_o : if0.rsp_valid_o;
  endfunction
  function automatic logic get_err(input int sel);
    return (sel == 1) ? if1.err_o : if0.err_o;
  endfunction
  function automatic logic [31:0] get_rdata(input int sel);
    return (sel == 1) ? if1.rdata_o : if0.rdata_o;
  endfunction

  function automatic logic ref_err(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'(DEPTH * 4));
  endfunction

  // One request from the idle negedge through the first idle cycle after the response.
  task automatic txn(input int sel, input logic we, input logic [31:0] a, input logic [31:0] d,
                     input bit junk, input logic exp_err, input logic [31:0] exp_rd,
                     input bit chk_rd);
    int w = (sel == 1) ? 1 : 0;
    chk("ready_before_req", 32'(get_ready(sel)), 32'd1);
    drive(sel, 1'b1, we, a, d);
    @(posedge clk);
    for (int k = 1; k <= w + 1; k++) begin
      @(negedge clk);
      if (k == w + 1) begin
        chk("rsp_valid_latency", 32'(get_rsp(sel)), 32'd1);
        chk("err", 32'(get_err(sel)), 32'(exp_err));
        if (chk_rd) chk("rdata", get_rdata(sel), exp_rd);
      end else begin
        chk("wait_outputs_quiet",
            {29'd0, get_rsp(sel), get_err(sel), |get_rdata(sel)}, 32'd0);
      end
      if (junk) drive(sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
      else      drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    end
    @(negedge clk);
    chk("rsp_one_cycle", 32'(get_rsp(sel)), 32'd0);
    chk("ready_after_rsp", 32'(get_ready(sel)), 32'd1);
    drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    if (we && !ref_err(a)) begin
      mdl[sel][a[9:2]]   = d;
      known[sel][a[9:2]] = 1'b1;
    end
  endtask

  initial begin
    tbl[0]  = '{1, 1'b1, 32'h014, 32'h1111_1111, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1, 1'b1, 32'h010, 32'hA5A5_0001, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1, 1'b0, 32'h010, 32'h0,         1'b1, 1'b0, 32'hA5A5_0001};
    tbl[3]  = '{1, 1'b1, 32'h013, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0};
    tbl[4]  = '{1, 1'b0, 32'h010, 32'h0,         1'b0, 1'b0, 32'hA5A5_0001};
    tbl[5]  = '{1, 1'b0, 32'h400, 32'h0,         1'b0, 1'b1, 32'h0};
    tbl[6]  = '{1, 1'b1, 32'h3FC, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0};
    tbl[7]  = '{1, 1'b0, 32'h3FC, 32'h0,         1'b0, 1'b0, 32'hCAFE_F00D};
    tbl[8]  = '{0, 1'b1, 32'h020, 32'h1234_5678, 1'b0, 1'b0, 32'h0};
    tbl[9]  = '{0, 1'b0, 32'h020, 32'h0,         1'b1, 1'b0, 32'h1234_5678};
    tbl[10] = '{0, 1'b0, 32'h002, 32'h0,         1'b0, 1'b1, 32'h0};
    tbl[11] = '{0, 1'b1, 32'h3FC, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0};
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < DEPTH; i++) known[s][i] = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);

    // Reset state of both instances.
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("reset_ready", 32'(get_ready(s)), 32'd1);
      chk("reset_outputs", {30'd0, get_rsp(s), get_err(s)} | get_rdata(s), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      txn(tbl[i].sel, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].junk,
          tbl[i].exp_err, tbl[i].exp_rdata, 1'b1);

    // Reset in the middle of a STORE's wait state must discard it.
    drive(1, 1'b1, 1'b1, 32'h014, 32'hDEAD_BEEF);
    @(posedge clk);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    arst_n = 1'b0;
    #1;
    chk("midreset_ready", 32'(get_ready(1)), 32'd1);
    chk("midreset_no_rsp", 32'(get_rsp(1)), 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("postreset_no_rsp", 32'(get_rsp(1)), 32'd0);
    end
    txn(1, 1'b0, 32'h014, 32'h0, 1'b0, 1'b0, 32'h1111_1111, 1'b1);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 80; n++) begin
      int          sel = $urandom_range(0, 1);
      logic        we  = 1'($urandom_range(0, 1));
      int          r   = $urandom_range(0, 9);
      logic [31:0] a;
      logic [31:0] d   = $urandom;
      logic        e;
      logic [31:0] x;
      bit          c;
      if (r == 0)      a = 32'($urandom_range(0, 1023)) | 32'd1;
      else if (r == 1) a = 32'($urandom_range(256, 4095)) << 2;
      else             a = 32'($urandom_range(0, 255)) << 2;
      e = ref_err(a);
      x = (we || e) ? 32'd0 : mdl[sel][a[9:2]];
      c = we || e || known[sel][a[9:2]];
      txn(sel, we, a, d, bit'($urandom_range(0, 1)), e, x, c);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
